harmonic_dds_bank: RTL and testbench



---
 rtl/dds_pkg.sv | 20 ++
 rtl/key_debounce.sv | 74 +++++++
 rtl/harmonic_dds_bank.sv | 142 ++++++++++++++
 tb/tb_harmonic_dds_bank.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared definitions for the harmonic DDS bank.
// - harm(k): harmonic number of channel k (1, 3, 5, ...)
// - step_idx_t / STEP_WRAP: step-size index and its modulus
// - sat_w(w): width of the word-update arithmetic. It has one extra bit so the
//   up/down result can be clamped without wrapping.
package dds_pkg;

  typedef logic [1:0] step_idx_t;

  localparam step_idx_t STEP_WRAP = 2'd3;

  function automatic int harm(input int k);
    return 2 * k + 1;
  endfunction

  function automatic int sat_w(input int acc_w);
    return acc_w + 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Key conditioner: 2-flop synchroniser, stable-sample debouncer and
// released->pressed event pulse.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   key      : raw asynchronous key level
//   ev       : one-cycle pulse when the accepted level becomes "pressed"
module key_debounce #(
  parameter int DEB_CYCLES = 250000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic ev
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);
  localparam logic RELEASED_RAW = ACTIVE_LOW;

  logic          sync1_reg;
  logic          sync2_reg;
  logic [1:0]    warm_reg;
  logic          armed_reg;
  logic          level_reg;
  logic [CW-1:0] cnt_reg;
  logic          ev_reg;
  logic          pressed;

  // Normalised key sample: 1 means pressed, whatever the pin polarity is.
  assign pressed = sync2_reg ^ RELEASED_RAW;
  assign ev      = ev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= RELEASED_RAW;
      sync2_reg <= RELEASED_RAW;
      warm_reg  <= 2'b00;
      armed_reg <= 1'b0;
      level_reg <= 1'b0;
      cnt_reg   <= '0;
      ev_reg    <= 1'b0;
    end else begin
      sync1_reg <= key;
      sync2_reg <= sync1_reg;
      warm_reg  <= {warm_reg[0], 1'b1};
      ev_reg    <= 1'b0;
      if (!warm_reg[1]) begin
        // The synchroniser still shows its reset value, not the pin.
        cnt_reg <= '0;
      end else if (!armed_reg) begin
        // The key must be seen released for a full debounce window before
        // any press is accepted. A key held through reset gives no event.
        if (pressed) begin
          cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
          armed_reg <= 1'b1;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else if (pressed == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == LAST) begin
        level_reg <= pressed;
        cnt_reg   <= '0;
        ev_reg    <= pressed;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/harmonic_dds_bank.sv
// Bank of NCH phase-aligned DDS square-wave generators. Channel k runs at
// harmonic 2k+1 of a fundamental word that three debounced keys adjust.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   key_up, key_dn, key_step : raw keys (increment, decrement, cycle step size)
//   out[NCH]                 : square outputs (MSB of each accumulator)
//   fw[ACC_W]                : current fundamental word
//   step_sel[2]              : current step-size index
//   mute[NCH]                : channel at or above Nyquist, held silent
module harmonic_dds_bank
  import dds_pkg::*;
#(
  parameter int ACC_W          = 24,
  parameter int NCH            = 3,
  parameter int FW_RESET       = 1678,
  parameter int FW_MIN         = 1,
  parameter int FW_MAX         = (1 << (ACC_W - 1)) - 1,
  parameter int STEP_0         = 16,
  parameter int STEP_1         = 1678,
  parameter int STEP_2         = 16777,
  parameter int DEB_CYCLES     = 250000,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_up,
  input  logic             key_dn,
  input  logic             key_step,
  output logic [NCH-1:0]   out,
  output logic [ACC_W-1:0] fw,
  output logic [1:0]       step_sel,
  output logic [NCH-1:0]   mute
);

  localparam int SW     = sat_w(ACC_W);
  // The product is wide enough for any harmonic number up to 255.
  localparam int PROD_W = ACC_W + 8;
  localparam logic [PROD_W-1:0] NYQ = PROD_W'(1) << (ACC_W - 1);

  logic ev_up;
  logic ev_dn;
  logic ev_step;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES), .ACTIVE_LOW(KEY_ACTIVE_LOW)) u_deb_up (
    .clk(clk), .rst(rst), .key(key_up), .ev(ev_up)
  );
  key_debounce #(.DEB_CYCLES(DEB_CYCLES), .ACTIVE_LOW(KEY_ACTIVE_LOW)) u_deb_dn (
    .clk(clk), .rst(rst), .key(key_dn), .ev(ev_dn)
  );
  key_debounce #(.DEB_CYCLES(DEB_CYCLES), .ACTIVE_LOW(KEY_ACTIVE_LOW)) u_deb_step (
    .clk(clk), .rst(rst), .key(key_step), .ev(ev_step)
  );

  logic [ACC_W-1:0] fw_reg;
  step_idx_t        step_reg;
  logic             resync_reg;
  logic [ACC_W-1:0] step_val;
  logic [SW-1:0]    up_sum;
  logic [SW-1:0]    dn_diff;
  logic [ACC_W-1:0] up_sat;
  logic [ACC_W-1:0] dn_sat;

  always_comb begin
    step_val = ACC_W'(STEP_0);
    case (step_reg)
      2'd1:    step_val = ACC_W'(STEP_1);
      2'd2:    step_val = ACC_W'(STEP_2);
      default: step_val = ACC_W'(STEP_0);
    endcase
  end

  // One extra bit: an overflow shows up as a large sum, and an underflow
  // sets the top bit of the difference.
  assign up_sum  = {1'b0, fw_reg} + {1'b0, step_val};
  assign dn_diff = {1'b0, fw_reg} - {1'b0, step_val};
  assign up_sat  = (up_sum > SW'(FW_MAX)) ? ACC_W'(FW_MAX) : up_sum[ACC_W-1:0];
  assign dn_sat  = (dn_diff[ACC_W] || (dn_diff < SW'(FW_MIN))) ? ACC_W'(FW_MIN)
                                                               : dn_diff[ACC_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      fw_reg     <= ACC_W'(FW_RESET);
      step_reg   <= '0;
      resync_reg <= 1'b0;
    end else begin
      resync_reg <= 1'b0;
      // Up and down in the same cycle cancel out: no update and no resync.
      // A clamped result that equals the old word still resyncs.
      if (ev_up ^ ev_dn) begin
        fw_reg     <= ev_up ? up_sat : dn_sat;
        resync_reg <= 1'b1;
      end
      // The up/down above already used the old step index.
      if (ev_step) begin
        step_reg <= (step_reg == STEP_WRAP - 2'd1) ? '0 : step_reg + 2'd1;
      end
    end
  end

  assign fw       = fw_reg;
  assign step_sel = step_reg;

  logic [ACC_W-1:0] hw_all  [NCH];
  logic [ACC_W-1:0] acc_all [NCH];

  for (genvar gi = 0; gi < NCH; gi++) begin : gen_ch
    localparam int H = harm(gi);
    localparam logic [PROD_W-1:0] PROD_RST = PROD_W'(FW_RESET) * PROD_W'(H);

    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  hw_reg;
    logic              mute_reg;
    logic [ACC_W-1:0]  acc_reg;

    assign prod = PROD_W'(fw_reg) * PROD_W'(H);

    // hw follows fw one cycle later. Because of that, the accumulator clear
    // driven by resync_reg lands on the same edge as the new hw. Every
    // channel therefore restarts from phase 0 together.
    always_ff @(posedge clk) begin
      if (rst) begin
        hw_reg   <= PROD_RST[ACC_W-1:0];
        mute_reg <= (PROD_RST >= NYQ);
        acc_reg  <= '0;
      end else begin
        hw_reg   <= prod[ACC_W-1:0];
        mute_reg <= (prod >= NYQ);
        if (resync_reg || mute_reg) begin
          acc_reg <= '0;
        end else begin
          acc_reg <= acc_reg + hw_reg;
        end
      end
    end

    assign out[gi]     = acc_reg[ACC_W-1];
    assign mute[gi]    = mute_reg;
    assign hw_all[gi]  = hw_reg;
    assign acc_all[gi] = acc_reg;
  end

endmodule

// File: tb/tb_harmonic_dds_bank.sv
// Scoreboard bench for harmonic_dds_bank (DEB_CYCLES = 4).
// The stimulus side updates a behavioural model of fw/step_sel and queues the
// expected result of each word update. The monitor waits for each resync and
// checks fw/step_sel in cycle t+1, then checks hw/mute/accumulators in t+2.
module tb_harmonic_dds_bank;

  localparam int ACC_W = 24;
  localparam int NCH   = 3;
  localparam longint FWMAX = 8388607;
  localparam longint NYQ   = 8388608;

  logic             clk = 1'b0;
  logic             rst;
  logic             key_up;
  logic             key_dn;
  logic             key_step;
  logic [NCH-1:0]   out;
  logic [ACC_W-1:0] fw;
  logic [1:0]       step_sel;
  logic [NCH-1:0]   mute;

  always #5 clk = ~clk;

  harmonic_dds_bank #(.DEB_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .key_up(key_up), .key_dn(key_dn), .key_step(key_step),
    .out(out), .fw(fw), .step_sel(step_sel), .mute(mute)
  );

  typedef struct {
    longint fw;
    int     step;
    longint hw0;
    longint hw1;
    longint hw2;
    int     mute;
  } exp_t;

  exp_t   q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  longint m_fw;
  int     m_step;
  int     steps[3] = '{16, 1678, 16777};

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk();
    exp_t e;
    longint p0 = m_fw;
    longint p1 = m_fw * 3;
    longint p2 = m_fw * 5;
    e.fw   = m_fw;
    e.step = m_step;
    e.hw0  = p0 % 16777216;
    e.hw1  = p1 % 16777216;
    e.hw2  = p2 % 16777216;
    e.mute = ((p2 >= NYQ) ? 4 : 0) + ((p1 >= NYQ) ? 2 : 0) + ((p0 >= NYQ) ? 1 : 0);
    return e;
  endfunction

  // Monitor: one line per word update.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (dut.resync_reg === 1'b1) begin
        if (q.size() == 0) begin
          check("unexpected_resync", 1, 0);
        end else begin
          e = q.pop_front();
          $display("update: fw=%0d step_sel=%0d (exp %0d/%0d)", fw, step_sel, e.fw, e.step);
          check("fw", fw, e.fw);
          check("step_sel", step_sel, e.step);
          @(posedge clk);
          #1;
          check("hw0", dut.hw_all[0], e.hw0);
          check("hw1", dut.hw_all[1], e.hw1);
          check("hw2", dut.hw_all[2], e.hw2);
          check("mute", mute, e.mute);
          check("acc0_clr", dut.acc_all[0], 0);
          check("acc1_clr", dut.acc_all[1], 0);
          check("acc2_clr", dut.acc_all[2], 0);
          check("out_clr", out, 0);
        end
      end
    end
  end

  // Press any key combination in the same cycle (active-low pins).
  task automatic press(input bit u, input bit d, input bit s);
    if (u ^ d) begin
      if (u) m_fw = (m_fw + steps[m_step] > FWMAX) ? FWMAX : m_fw + steps[m_step];
      else   m_fw = (m_fw - steps[m_step] < 1) ? 1 : m_fw - steps[m_step];
    end
    if (s) m_step = (m_step + 1) % 3;
    if (u ^ d) q.push_back(mk());
    @(negedge clk);
    key_up   = !u;
    key_dn   = !d;
    key_step = !s;
    repeat (10) @(negedge clk);
    key_up   = 1'b1;
    key_dn   = 1'b1;
    key_step = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic do_reset();
    check("queue_drained", q.size(), 0);
    @(negedge clk);
    rst = 1'b1;
    key_up = 1'b1; key_dn = 1'b1; key_step = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_fw = 1678;
    m_step = 0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    int toggles;
    int t1;
    int hi2;
    logic prev;
    rst = 1'b1;
    key_up = 1'b1; key_dn = 1'b1; key_step = 1'b1;
    m_fw = 1678;
    m_step = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_fw", fw, 1678);
    check("rst_step", step_sel, 0);
    check("rst_mute", mute, 0);
    check("rst_out", out, 0);
    check("rst_hw0", dut.hw_all[0], 1678);
    check("rst_hw1", dut.hw_all[1], 5034);
    check("rst_hw2", dut.hw_all[2], 8390);
    rst = 1'b0;
    // out[0] rises after 5000 cycles and falls after 9999 cycles.
    toggles = 0;
    prev = out[0];
    for (int i = 0; i < 10050; i++) begin
      @(negedge clk);
      if (out[0] != prev) toggles++;
      prev = out[0];
    end
    check("out0_toggles", toggles, 2);
    $display("period: out0 toggled %0d times in 10050 cycles", toggles);

    // Single up press: 1678 + 16
    press(1, 0, 0);
    check("up_fw", m_fw, 1694);
    check("up_fw_dut", fw, 1694);

    // Bounce rejection: key_dn toggles every 2 cycles, then is held pressed
    do_reset();
    m_fw = 1662;
    q.push_back(mk());
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      key_dn = ~key_dn;
      @(negedge clk);
    end
    key_dn = 1'b0;
    repeat (12) @(negedge clk);
    key_dn = 1'b1;
    repeat (12) @(negedge clk);
    check("bounce_fw", fw, 1662);

    // Lower bound: step 1678, two decrements
    do_reset();
    press(0, 0, 1);
    check("step_sel_1", step_sel, 1);
    press(0, 1, 0);
    check("low_fw1", fw, 1);
    press(0, 1, 0);
    check("low_fw2", fw, 1);

    // Simultaneous up+down is ignored; step together with up uses the old step
    do_reset();
    press(1, 1, 0);
    check("both_fw", fw, 1678);
    press(1, 0, 1);
    check("stepup_fw", fw, 1694);
    check("stepup_sel", step_sel, 1);

    // Saturation and mute at step 16777
    do_reset();
    press(0, 0, 1);
    press(0, 0, 1);
    check("step_sel_2", step_sel, 2);
    for (int i = 0; i < 100; i++) press(1, 0, 0);
    check("sat_fw100", fw, 1679378);
    check("mute_100", mute, 3'b100);
    t1 = 0;
    hi2 = 0;
    prev = out[1];
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out[1] != prev) t1++;
      prev = out[1];
      if (out[2]) hi2++;
    end
    check("out2_silent", hi2, 0);
    check("out1_toggles", (t1 > 10) ? 1 : 0, 1);
    while (m_fw < FWMAX) press(1, 0, 0);
    press(1, 0, 0);
    press(1, 0, 0);
    check("clamp_fw", fw, FWMAX);
    check("clamp_mute", mute, 3'b110);

    repeat (20) @(negedge clk);
    check("queue_final", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
